instr_fetch_unit: RTL and testbench

//   Downstream consumer of the program counter in the multi-cycle MIPS core.
//   On a fetch command from the control FSM: captures pcout, reads instruction memory

---
 rtl/mips_pkg.sv | 16 +
 rtl/fetch_timer.sv | 31 +++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS core: instruction-fetch state
// encodings, the reset instruction word and the instruction size in bytes.
package mips_pkg;

    typedef logic [1:0] if_state_t;

    localparam if_state_t IF_IDLE  = 2'd0;
    localparam if_state_t IF_REQ   = 2'd1;
    localparam if_state_t IF_DONE  = 2'd2;
    localparam if_state_t IF_FAULT = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/fetch_timer.sv
// Wait-cycle counter for memory handshakes: cleared while idle, counts while
// enabled and flags the last allowed wait cycle.
module fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Holds at LAST so a stalled owner never sees the count wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: captures the PC on a fetch command, reads the word over
// a req/ack handshake into IR, publishes PC+4 and flags misaligned/timed-out fetches.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 TIMEOUT  = 16,
    parameter logic [DATA_W-1:0]  RESET_IR = DATA_W'(NOP_INSTR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              ir_valid,
    output logic              busy,
    output logic              fault
);

    if_state_t         state;
    if_state_t         state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic              tmr_expired;
    logic              capture;
    logic              load_ir;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != IF_REQ),
        .en      (state == IF_REQ),
        .expired (tmr_expired)
    );

    // flush overrides every transition, including a same-cycle mem_ack.
    always_comb begin
        state_nx = state;
        unique case (state)
            IF_IDLE: begin
                if (fetch) begin
                    state_nx = (pc[1:0] != 2'b00) ? IF_FAULT : IF_REQ;
                end
            end
            IF_REQ: begin
                if (mem_ack) begin
                    state_nx = IF_DONE;
                end else if (tmr_expired) begin
                    state_nx = IF_FAULT;
                end
            end
            IF_DONE:  state_nx = IF_IDLE;
            IF_FAULT: state_nx = IF_IDLE;
            default:  state_nx = IF_IDLE;
        endcase
        if (flush) begin
            state_nx = IF_IDLE;
        end
    end

    assign capture = (state == IF_IDLE) && fetch && !flush;
    assign load_ir = (state == IF_REQ) && mem_ack && !flush;

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IF_IDLE;
            addr_q   <= '0;
            ir       <= RESET_IR;
            pc_plus4 <= '0;
            mem_req  <= 1'b0;
            ir_valid <= 1'b0;
            fault    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            mem_req  <= (state_nx == IF_REQ);
            ir_valid <= (state_nx == IF_DONE);
            fault    <= (state_nx == IF_FAULT);
            busy     <= (state_nx != IF_IDLE);
            if (capture) begin
                addr_q <= pc;
            end
            if (load_ir) begin
                ir       <= mem_rdata;
                pc_plus4 <= addr_q + ADDR_W'(WORD_BYTES);
            end
        end
    end

    assign mem_addr = addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle-by-cycle vector table plus
// hand-written timeout and PC-wrap/back-to-back sequences (TIMEOUT=4).
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        fetch;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ir;
    logic [31:0] pc_plus4;
    logic        ir_valid;
    logic        busy;
    logic        fault;

    int n_vec = 0;
    int n_bad = 0;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (4),
        .RESET_IR (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .fetch     (fetch),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .pc_plus4  (pc_plus4),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {mem_req, busy, ir_valid, fault}
    typedef struct {
        string       nm;
        logic        rst_n;
        logic        fetch;
        logic        flush;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rdata;
        logic [3:0]  ctl;
        logic [31:0] ir;
        logic [31:0] pp4;
        logic [31:0] addr;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    function automatic vec_t mk(input string nm, input logic r, input logic f, input logic fl,
                                input logic [31:0] p, input logic a, input logic [31:0] d,
                                input logic [3:0] c, input logic [31:0] i,
                                input logic [31:0] pp, input logic [31:0] ad);
        vec_t v;
        v.nm = nm; v.rst_n = r; v.fetch = f; v.flush = fl; v.pc = p; v.ack = a;
        v.rdata = d; v.ctl = c; v.ir = i; v.pp4 = pp; v.addr = ad;
        return v;
    endfunction

    task automatic drive(input logic r, input logic f, input logic fl, input logic [31:0] p,
                         input logic a, input logic [31:0] d);
        rst_n = r; fetch = f; flush = fl; pc = p; mem_ack = a; mem_rdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] ctl_e, input logic [31:0] ir_e,
                         input logic [31:0] pp_e, input logic [31:0] addr_e);
        n_vec++;
        if ({mem_req, busy, ir_valid, fault} !== ctl_e || ir !== ir_e ||
            pc_plus4 !== pp_e || mem_addr !== addr_e) begin
            n_bad++;
            $display("FAIL %s: req/busy/irv/fault=%b ir=%h pc_plus4=%h addr=%h, expected %b %h %h %h",
                     nm, {mem_req, busy, ir_valid, fault}, ir, pc_plus4, mem_addr,
                     ctl_e, ir_e, pp_e, addr_e);
        end
    endtask

    initial begin
        //               name            rst f fl pc            ack rdata          ctl      ir            pc_plus4      addr
        vecs[0]  = mk("reset0",        0, 1, 0, 32'd244,      0, 32'h0,         4'b0000, 32'h0,        32'h0,        32'h0);
        vecs[1]  = mk("reset1",        0, 1, 0, 32'd244,      0, 32'h0,         4'b0000, 32'h0,        32'h0,        32'h0);
        vecs[2]  = mk("basic_req1",    1, 1, 0, 32'd244,      0, 32'h0,         4'b1100, 32'h0,        32'h0,        32'd244);
        vecs[3]  = mk("basic_req2",    1, 0, 0, 32'd0,        0, 32'h0,         4'b1100, 32'h0,        32'h0,        32'd244);
        vecs[4]  = mk("basic_done",    1, 0, 0, 32'd0,        1, 32'h2008_0005, 4'b0110, 32'h2008_0005, 32'd248,     32'd244);
        vecs[5]  = mk("basic_idle",    1, 0, 0, 32'd0,        0, 32'h0,         4'b0000, 32'h2008_0005, 32'd248,     32'd244);
        vecs[6]  = mk("ack_in_idle",   1, 0, 0, 32'd0,        1, 32'hDEAD_BEEF, 4'b0000, 32'h2008_0005, 32'd248,     32'd244);
        vecs[7]  = mk("misalign_flt",  1, 1, 0, 32'd246,      0, 32'h0,         4'b0101, 32'h2008_0005, 32'd248,     32'd246);
        vecs[8]  = mk("misalign_idle", 1, 0, 0, 32'd0,        0, 32'h0,         4'b0000, 32'h2008_0005, 32'd248,     32'd246);
        vecs[9]  = mk("flush_req",     1, 1, 0, 32'h200,      0, 32'h0,         4'b1100, 32'h2008_0005, 32'd248,     32'h200);
        vecs[10] = mk("flush_ack",     1, 0, 1, 32'd0,        1, 32'h1111_1111, 4'b0000, 32'h2008_0005, 32'd248,     32'h200);
        vecs[11] = mk("refetch_req",   1, 1, 0, 32'h104,      0, 32'h0,         4'b1100, 32'h2008_0005, 32'd248,     32'h104);
        vecs[12] = mk("refetch_done",  1, 0, 0, 32'd0,        1, 32'h8C22_0004, 4'b0110, 32'h8C22_0004, 32'h108,     32'h104);
        vecs[13] = mk("fetch_in_done", 1, 1, 0, 32'h300,      0, 32'h0,         4'b0000, 32'h8C22_0004, 32'h108,     32'h104);
        vecs[14] = mk("fetch_flush",   1, 1, 1, 32'h104,      0, 32'h0,         4'b0000, 32'h8C22_0004, 32'h108,     32'h104);
        vecs[15] = mk("busy_req1",     1, 1, 0, 32'h500,      0, 32'h0,         4'b1100, 32'h8C22_0004, 32'h108,     32'h500);
        vecs[16] = mk("fetch_in_req",  1, 1, 0, 32'h600,      0, 32'h0,         4'b1100, 32'h8C22_0004, 32'h108,     32'h500);
        vecs[17] = mk("flush_only",    1, 0, 1, 32'h0,        0, 32'h0,         4'b0000, 32'h8C22_0004, 32'h108,     32'h500);
        vecs[18] = mk("rst_mid_req",   1, 1, 0, 32'h700,      0, 32'h0,         4'b1100, 32'h8C22_0004, 32'h108,     32'h700);
        vecs[19] = mk("rst_with_ack",  0, 0, 0, 32'h0,        1, 32'hABCD_0000, 4'b0000, 32'h0,        32'h0,        32'h0);
        vecs[20] = mk("post_reset",    1, 0, 0, 32'h0,        0, 32'h0,         4'b0000, 32'h0,        32'h0,        32'h0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst_n, vecs[i].fetch, vecs[i].flush, vecs[i].pc, vecs[i].ack, vecs[i].rdata);
            tick();
            check(vecs[i].nm, vecs[i].ctl, vecs[i].ir, vecs[i].pp4, vecs[i].addr);
        end

        // Timeout: no ack, mem_req stays up for exactly TIMEOUT cycles, then fault.
        drive(1, 1, 0, 32'h100, 0, 32'h0);
        tick();
        check("tmo_req1", 4'b1100, 32'h0, 32'h0, 32'h100);
        drive(1, 0, 0, 32'h0, 0, 32'h0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check($sformatf("tmo_req%0d", c), 4'b1100, 32'h0, 32'h0, 32'h100);
        end
        tick();
        check("tmo_fault", 4'b0101, 32'h0, 32'h0, 32'h100);
        tick();
        check("tmo_idle", 4'b0000, 32'h0, 32'h0, 32'h100);

        // Wrap and back-to-back fetch.
        drive(1, 1, 0, 32'h10, 0, 32'h0);
        tick();
        check("w_req_a", 4'b1100, 32'h0, 32'h0, 32'h10);
        drive(1, 0, 0, 32'h0, 1, 32'h0000_0001);
        tick();
        check("w_done_a", 4'b0110, 32'h1, 32'h14, 32'h10);
        drive(1, 0, 0, 32'h0, 0, 32'h0);
        tick();
        check("w_idle_a", 4'b0000, 32'h1, 32'h14, 32'h10);
        drive(1, 1, 0, 32'hFFFF_FFFC, 0, 32'h0);
        tick();
        check("w_req_wrap", 4'b1100, 32'h1, 32'h14, 32'hFFFF_FFFC);
        drive(1, 0, 0, 32'h0, 1, 32'h2402_000A);
        tick();
        check("w_done_wrap", 4'b0110, 32'h2402_000A, 32'h0, 32'hFFFF_FFFC);
        drive(1, 1, 0, 32'h20, 0, 32'h0);
        tick();
        check("w_fetch_in_done", 4'b0000, 32'h2402_000A, 32'h0, 32'hFFFF_FFFC);
        tick();
        check("w_refetch_req", 4'b1100, 32'h2402_000A, 32'h0, 32'h20);
        drive(1, 0, 0, 32'h0, 1, 32'h0000_0003);
        tick();
        check("w_refetch_done", 4'b0110, 32'h3, 32'h24, 32'h20);
        drive(1, 0, 0, 32'h0, 0, 32'h0);
        tick();
        check("w_final_idle", 4'b0000, 32'h3, 32'h24, 32'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
